// File: rtl/i2c_xfer_ctrl.sv
// Transaction sequencer in front of the udp_i2c master: issues one request at a time,
// buffers read bytes in a first-word fall-through FIFO and reports status/count on done.
module i2c_xfer_ctrl #(
  parameter int MAX_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_read,
  input  logic [7:0] req_slave_addr,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_len,
  input  logic [7:0] req_wdata,
  output logic [7:0] i2c_slave_addr,
  output logic [7:0] mst_command_byte,
  output logic [7:0] mst_num_bytes,
  output logic [7:0] mst_din,
  output logic       mst_read,
  output logic       mst_write,
  input  logic       mst_data_out_valid,
  input  logic [7:0] mst_data_out,
  input  logic       mst_write_done,
  input  logic       i2c_arb_lost,
  output logic       i2c_arb_lost_clr,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic       rd_ready,
  output logic       done,
  output logic [1:0] status,
  output logic [7:0] rd_count
);
  localparam int PW = $clog2(MAX_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN    = 8'(MAX_BYTES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_RD = 3'd2;
  localparam logic [2:0] S_WAIT_WR = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ARB     = 2'd2;
  localparam logic [1:0] ST_BAD_LEN = 2'd3;

  logic [2:0]    state_reg;
  logic          read_reg;
  logic [TW-1:0] timer_reg;
  logic [7:0]    byte_cnt_reg;
  logic [1:0]    xfer_status_reg;
  logic [7:0]    byte_cnt_next;
  logic          in_wait;
  logic          timed_out;
  logic          push;
  logic          pop;

  logic [7:0]    fifo_mem [MAX_BYTES];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;

  assign in_wait          = (state_reg == S_WAIT_RD) || (state_reg == S_WAIT_WR);
  assign timed_out        = (timer_reg == TIMER_LAST);
  assign byte_cnt_next    = byte_cnt_reg + 8'd1;
  assign req_ready        = (state_reg == S_IDLE);
  assign mst_read         = (state_reg == S_ISSUE) && read_reg;
  assign mst_write        = (state_reg == S_ISSUE) && !read_reg;
  assign i2c_arb_lost_clr = in_wait && i2c_arb_lost;
  // A byte arriving together with arbitration loss is dropped.
  assign push             = (state_reg == S_WAIT_RD) && mst_data_out_valid && !i2c_arb_lost;
  assign pop              = rd_valid && rd_ready;
  assign rd_valid         = (count_reg != '0);
  assign rd_data          = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      read_reg         <= 1'b0;
      timer_reg        <= '0;
      byte_cnt_reg     <= '0;
      xfer_status_reg  <= ST_OK;
      i2c_slave_addr   <= '0;
      mst_command_byte <= '0;
      mst_num_bytes    <= '0;
      mst_din          <= '0;
      done             <= 1'b0;
      status           <= ST_OK;
      rd_count         <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            i2c_slave_addr   <= req_slave_addr;
            mst_command_byte <= req_cmd;
            mst_num_bytes    <= req_len;
            mst_din          <= req_wdata;
            read_reg         <= req_read;
            byte_cnt_reg     <= '0;
            timer_reg        <= '0;
            if (req_read && ((req_len == 8'd0) || (req_len > MAX_LEN))) begin
              xfer_status_reg <= ST_BAD_LEN;
              state_reg       <= S_FINISH;
            end else begin
              state_reg <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state_reg <= read_reg ? S_WAIT_RD : S_WAIT_WR;
        S_WAIT_RD: begin
          if (i2c_arb_lost) begin
            xfer_status_reg <= ST_ARB;
            state_reg       <= S_FINISH;
          end else if (push) begin
            byte_cnt_reg <= byte_cnt_next;
            timer_reg    <= '0;
            if (byte_cnt_next == mst_num_bytes) begin
              xfer_status_reg <= ST_OK;
              state_reg       <= S_FINISH;
            end
          end else if (timed_out) begin
            xfer_status_reg <= ST_TIMEOUT;
            state_reg       <= S_FINISH;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_WAIT_WR: begin
          if (i2c_arb_lost) begin
            xfer_status_reg <= ST_ARB;
            state_reg       <= S_FINISH;
          end else if (mst_write_done) begin
            xfer_status_reg <= ST_OK;
            state_reg       <= S_FINISH;
          end else if (timed_out) begin
            xfer_status_reg <= ST_TIMEOUT;
            state_reg       <= S_FINISH;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_FINISH: begin
          done      <= 1'b1;
          status    <= xfer_status_reg;
          rd_count  <= byte_cnt_reg;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and occupancy define contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= mst_data_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule
